// File: rtl/fft_stage_ctrl_if.sv
// fft_stage_ctrl_if: run control, butterfly issue and writeback signals of the FFT stage sequencer.
interface fft_stage_ctrl_if #(parameter int LOG2N = 8);
   logic start, abort, bfly_ready, wb_valid;
   logic bfly_valid, stage_strobe, fft_done, busy;
   logic [LOG2N-1:0] addr_a, addr_b;
   logic [LOG2N-2:0] tw_idx;
   logic [3:0] stage_num;
   modport master (
      input start, abort, bfly_ready, wb_valid,
      output bfly_valid, addr_a, addr_b, tw_idx, stage_num, stage_strobe, fft_done, busy
   );
   modport slave (
      output start, abort, bfly_ready, wb_valid,
      input bfly_valid, addr_a, addr_b, tw_idx, stage_num, stage_strobe, fft_done, busy
   );
endinterface

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: sequences in-place radix-2 butterflies stage by stage and
// waits for every writeback of a stage before starting the next one.
module fft_stage_ctrl #(parameter int LOG2N = 8) (
   input logic clk,
   input logic reset,
   fft_stage_ctrl_if.master bus
);
   localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, DRAIN = 3'd2, STAGE_END = 3'd3, DONE = 3'd4;
   localparam logic [LOG2N-1:0] HALF = LOG2N'(1) << (LOG2N - 1);
   logic [2:0] state;
   logic [3:0] stage;
   logic [LOG2N-2:0] j, mask;
   logic [LOG2N-1:0] wb_cnt, wb_next, grp;
   logic wb_inc;
   // mask keeps j mod 2^s; it wraps to all ones on the last stage, where span exceeds any j
   always_comb begin
      mask = ((LOG2N-1)'(1) << stage) - (LOG2N-1)'(1);
      grp = {1'b0, j} >> stage;
      bus.addr_a = (grp << (stage + 4'd1)) | {1'b0, j & mask};
      bus.addr_b = bus.addr_a + (LOG2N'(1) << stage);
      bus.tw_idx = (j & mask) << (4'(LOG2N - 1) - stage);
      wb_inc = bus.wb_valid && (state == ISSUE || state == DRAIN);
      wb_next = wb_cnt + LOG2N'(wb_inc);
   end
   assign bus.bfly_valid = state == ISSUE;
   assign bus.stage_strobe = state == STAGE_END;
   assign bus.fft_done = state == DONE;
   assign bus.busy = state != IDLE;
   assign bus.stage_num = stage;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         stage <= '0;
         j <= '0;
         wb_cnt <= '0;
      end else if (bus.abort) begin
         state <= IDLE;
         j <= '0;
         wb_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               state <= ISSUE;
               stage <= '0;
               j <= '0;
               wb_cnt <= '0;
            end
            ISSUE: begin
               wb_cnt <= wb_next;
               if (bus.bfly_ready) begin
                  j <= j + (LOG2N-1)'(1);
                  state <= (&j) ? DRAIN : ISSUE;
               end
            end
            DRAIN: begin
               wb_cnt <= wb_next;
               state <= (wb_next >= HALF) ? STAGE_END : DRAIN;
            end
            STAGE_END: begin
               wb_cnt <= '0;
               state <= (stage == 4'(LOG2N - 1)) ? DONE : ISSUE;
               stage <= (stage == 4'(LOG2N - 1)) ? stage : stage + 4'd1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/fft_stage_ctrl.md
FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

Interface
REQ-001 Parameter LOG2N, default 8, meaning log2 of FFT length; N = 2^LOG2N points, N/2 butterflies per stage, LOG2N stages.
REQ-002 The block SHALL have the port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have the port start, input, 1 bit, which begins a full FFT when sampled high in IDLE.
REQ-005 The block SHALL have the port abort, input, 1 bit, a synchronous cancel of the current FFT.
REQ-006 The block SHALL have the port bfly_ready, input, 1 bit, meaning the butterfly unit accepts the presented operation this cycle.
REQ-007 The block SHALL have the port wb_valid, input, 1 bit, meaning one butterfly result has been written back to memory this cycle.
REQ-008 The block SHALL have the port bfly_valid, output, 1 bit, meaning the butterfly operation on addr_a/addr_b/tw_idx is valid.
REQ-009 The block SHALL have the port addr_a, output, LOG2N bits, the upper-leg sample address.
REQ-010 The block SHALL have the port addr_b, output, LOG2N bits, the lower-leg sample address.
REQ-011 The block SHALL have the port tw_idx, output, LOG2N-1 bits, the twiddle ROM index.
REQ-012 The block SHALL have the port stage_num, output, 4 bits, the current stage index 0..LOG2N-1.
REQ-013 The block SHALL have the port stage_strobe, output, 1 bit, a one-cycle pulse when a stage has fully written back.
REQ-014 The block SHALL have the port fft_done, output, 1 bit, a one-cycle pulse when the last stage completes.
REQ-015 The block SHALL have the port busy, output, 1 bit, high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, ISSUE, DRAIN, STAGE_END and DONE.
REQ-017 In IDLE, start=1 SHALL clear stage_num, bfly index j and writeback count wb_cnt to 0 and move to ISSUE; bfly_valid rises the next cycle.
REQ-018 In any state other than IDLE, start SHALL be ignored.
REQ-019 In ISSUE, bfly_valid SHALL be 1, with operands driven combinationally from stage_num=s and j.
REQ-020 Operand formula: span=2^s; pos=j mod span; grp=j>>s.
REQ-021 addr_a SHALL equal (grp<<(s+1))|pos, and addr_b SHALL equal addr_a+span.
REQ-022 tw_idx SHALL equal pos<<(LOG2N-1-s), truncated to LOG2N-1 bits.
REQ-023 Handshake: j SHALL advance only on bfly_valid&bfly_ready, and the operands SHALL be held stable while bfly_ready=0.
REQ-024 An accept with j=N/2-1 SHALL move the FSM to DRAIN and drop bfly_valid, with j wrapping to 0.
REQ-025 wb_cnt SHALL increment on every wb_valid in ISSUE or DRAIN, including writebacks that arrive while the stage is still issuing.
REQ-026 wb_valid SHALL be ignored in IDLE, STAGE_END and DONE.
REQ-027 In DRAIN, when wb_cnt reaches N/2 (counting a wb_valid in the current cycle), the FSM SHALL go to STAGE_END the next cycle.
REQ-028 In STAGE_END, stage_strobe SHALL be 1 for that single cycle and wb_cnt SHALL clear.
REQ-029 From STAGE_END, if stage_num=LOG2N-1 the FSM SHALL go to DONE; otherwise stage_num SHALL increment and the FSM SHALL go to ISSUE.
REQ-030 In DONE, fft_done SHALL be 1 for one cycle, then the FSM SHALL go to IDLE with stage_num held at LOG2N-1.
REQ-031 abort=1 SHALL force IDLE next cycle from any state and clear j and wb_cnt.
REQ-032 abort SHALL have priority over start and over all other transitions, and SHALL produce no stage_strobe and no fft_done.
REQ-033 In IDLE, bfly_valid, stage_strobe and fft_done SHALL be 0.
REQ-034 The output and operand latency SHALL be zero cycles from state, stage_num and j.

Reset
REQ-035 reset=1 at a clock edge SHALL force IDLE, j=0, wb_cnt=0 and stage_num=0.
REQ-036 Under reset, all of bfly_valid, stage_strobe, fft_done and busy SHALL be 0, and addr_a=0, addr_b=1, tw_idx=0.
REQ-037 reset SHALL take priority over abort and start, and a reset mid-FFT SHALL discard all progress with no pulses.

Verification
REQ-038 The bench SHALL apply start with bfly_ready=1 and wb_valid echoing each accept 3 cycles later, and check exactly 8 stage_strobe pulses (stage_num 0..7), one fft_done, and 8*128 accepts.
REQ-039 The bench SHALL check operands: stage 0 j=5 gives a=10, b=11, tw=0; stage 3 j=13 gives a=21, b=29, tw=80; stage 7 j=127 gives a=127, b=255, tw=127.
REQ-040 The bench SHALL toggle bfly_ready pseudo-randomly and check that addr_a, addr_b and tw_idx stay stable while bfly_valid=1 and bfly_ready=0.
REQ-041 The bench SHALL hold wb_valid low after the last accept of stage 2, check that the FSM stays in DRAIN with no stage_strobe, then supply the 128th wb_valid and check stage_strobe exactly 1 cycle later.
REQ-042 The bench SHALL assert abort during stage 4 DRAIN together with start, check busy=0 next cycle with no fft_done, then start again and check the run begins at stage_num=0, j=0.
REQ-043 The bench SHALL assert reset mid-ISSUE of stage 6 and check that all outputs match the REQ-036 values on the following cycle.
